// File: rtl/clkdiv_multi.sv
// Free-running count plus N_CH run-time programmable clock-enable dividers.
// Each channel emits a one-cycle tick every D enabled cycles and a square wave that toggles on every tick.
module clkdiv_multi #(
  parameter int WIDTH   = 32,
  parameter int N_CH    = 4,
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [3:0]       ch_sel_i,
  input  logic [DIV_W-1:0] div_val_i,
  output logic [WIDTH-1:0] clkdiv_o,
  output logic [N_CH-1:0]  tick_o,
  output logic [N_CH-1:0]  sq_o
);

  logic [WIDTH-1:0] clkdiv_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) clkdiv_q <= '0;
    else         clkdiv_q <= clkdiv_q + WIDTH'(1);
  end

  assign clkdiv_o = clkdiv_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             sel;

    // Out-of-range channel selects match no channel and are dropped silently.
    assign sel = load_i && (ch_sel_i == 4'(gi));

    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sel) begin
        div_d = div_val_i;
        cnt_d = '0;
      end else if (!en_i) begin
        cnt_d = cnt_q;
      end else if (div_q == '0) begin
        cnt_d = '0;
      end else if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        div_q  <= DIV_W'(DEF_DIV);
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick_o[gi] = tick_q;
    assign sq_o[gi]   = sq_q;
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: a cycles-remaining reference model checked every cycle against a
// full-width instance and an 8-bit-count instance, plus hand-computed pinning checks.
module tb_clkdiv_multi;
  localparam int N_CH    = 4;
  localparam int DIV_W   = 16;
  localparam int DEF_DIV = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, en, load;
  logic [3:0]       ch_sel;
  logic [DIV_W-1:0] div_val;
  logic [31:0]      clkdiv;
  logic [7:0]       clkdiv8;
  logic [N_CH-1:0]  tick, sq, tick8, sq8;

  clkdiv_multi #(.WIDTH(32), .N_CH(N_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .ch_sel_i(ch_sel),
    .div_val_i(div_val), .clkdiv_o(clkdiv), .tick_o(tick), .sq_o(sq)
  );

  clkdiv_multi #(.WIDTH(8), .N_CH(N_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .ch_sel_i(ch_sel),
    .div_val_i(div_val), .clkdiv_o(clkdiv8), .tick_o(tick8), .sq_o(sq8)
  );

  int checks = 0;
  int errors = 0;

  // Model: edges since reset, and per channel the enabled edges left until the next tick.
  longint          ncyc;
  int              rem_m[N_CH];
  int              div_m[N_CH];
  logic [N_CH-1:0] tick_m, sq_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, ncyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ncyc = 0;
    for (int i = 0; i < N_CH; i++) begin
      rem_m[i] = DEF_DIV;
      div_m[i] = DEF_DIV;
    end
    tick_m = '0;
    sq_m   = '0;
  endtask

  task automatic model_edge();
    ncyc++;
    for (int i = 0; i < N_CH; i++) begin
      tick_m[i] = 1'b0;
      if (load && int'(ch_sel) == i) begin
        div_m[i] = int'(div_val);
        rem_m[i] = int'(div_val);
      end else if (en && div_m[i] != 0) begin
        rem_m[i]--;
        if (rem_m[i] == 0) begin
          tick_m[i] = 1'b1;
          sq_m[i]   = !sq_m[i];
          rem_m[i]  = div_m[i];
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("clkdiv",  64'(clkdiv),  64'(ncyc % 64'h1_0000_0000));
    chk("clkdiv8", 64'(clkdiv8), 64'(ncyc % 256));
    chk("tick",    64'(tick),    64'(tick_m));
    chk("sq",      64'(sq),      64'(sq_m));
    chk("tick8",   64'(tick8),   64'(tick_m));
    chk("sq8",     64'(sq8),     64'(sq_m));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_load(input int ch, input int d);
    ch_sel  = 4'(ch);
    div_val = DIV_W'(d);
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_clkdiv"}, 64'(clkdiv), 0);
    chk({name, "_tick"},   64'(tick),   0);
    chk({name, "_sq"},     64'(sq),     0);
    chk({name, "_clkdiv8"}, 64'(clkdiv8), 0);
  endtask

  logic   s;
  longint cd;
  int     found;

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; ch_sel = '0; div_val = '0;
    model_reset();
    #1 check_zero("reset0");
    @(negedge clk);
    rst_n = 1'b1;

    step();
    chk("first_inc", 64'(clkdiv), 1);
    run(254);
    chk("wrap8_pre", 64'(clkdiv8), 255);
    step();
    chk("wrap8_zero", 64'(clkdiv8), 0);
    run(743);
    chk("ch0_pre", 64'(tick[0]), 0);
    step();
    chk("ch0_tick1000", 64'(tick[0]), 1);
    step();
    chk("ch0_post", 64'(tick[0]), 0);

    // D=5 on ch1: first tick 5 edges after load, then every 5, sq period 10.
    do_load(1, 5);
    run(4);
    chk("ch1_pre", 64'(tick[1]), 0);
    step();
    chk("ch1_first", 64'(tick[1]), 1);
    s = sq[1];
    run(5);
    chk("ch1_second", 64'(tick[1]), 1);
    chk("ch1_sq_half", 64'(sq[1]), 64'(!s));
    run(5);
    chk("ch1_sq_full", 64'(sq[1]), 64'(s));

    // D=1 then D=0 on ch2.
    do_load(2, 1);
    step();
    chk("ch2_d1_tick", 64'(tick[2]), 1);
    s = sq[2];
    step();
    chk("ch2_d1_tick2", 64'(tick[2]), 1);
    chk("ch2_d1_sq", 64'(sq[2]), 64'(!s));
    run(6);
    do_load(2, 0);
    s = sq[2];
    run(20);
    chk("ch2_d0_tick", 64'(tick[2]), 0);
    chk("ch2_d0_sq", 64'(sq[2]), 64'(s));

    // D=4 on ch3 with en low for 3 cycles mid-period: tick moves from t+4 to t+7.
    do_load(3, 4);
    step();
    cd = 64'(clkdiv);
    en = 1'b0;
    run(3);
    chk("pause_clkdiv", 64'(clkdiv), 64'(cd + 3));
    en = 1'b1;
    run(2);
    chk("pause_pre", 64'(tick[3]), 0);
    step();
    chk("pause_tick", 64'(tick[3]), 1);

    // Load on the terminal-count edge: no tick, sq held, new period restarts.
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (rem_m[3] == 1) found = 1;
      else step();
    end
    chk("collision_wait", 64'(found), 1);
    s = sq[3];
    do_load(3, 4);
    chk("collision_tick", 64'(tick[3]), 0);
    chk("collision_sq", 64'(sq[3]), 64'(s));
    run(3);
    chk("collision_pre", 64'(tick[3]), 0);
    step();
    chk("collision_next", 64'(tick[3]), 1);

    // Out-of-range select: every channel must keep its phase (model checks each cycle).
    do_load(N_CH, 7);
    do_load(15, 2);
    run(12);

    // Asynchronous reset mid-run with ticks pending.
    #2 rst_n = 1'b0;
    #1 check_zero("reset_mid");
    model_reset();
    @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    step();
    chk("reset_first_inc", 64'(clkdiv), 1);
    run(998);
    chk("reset_ch0_pre", 64'(tick[0]), 0);
    step();
    chk("reset_ch0_tick", 64'(tick[0]), 1);

    // Randomized traffic, including out-of-range selects and D in 0..12.
    repeat (3000) begin
      en      = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 5) == 0);
      ch_sel  = 4'($urandom_range(0, 5));
      div_val = DIV_W'($urandom_range(0, 12));
      step();
    end
    load = 1'b0;
    en   = 1'b1;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/clkdiv_multi.md
# clkdiv_multi

Parametrised multi-channel clock-enable generator, successor to the single free-running divider counter. It keeps a free-running WIDTH-bit count and adds N_CH independent, run-time programmable dividers. Each divider emits a one-cycle tick and a 50 % square wave. It sits beside the top-level clock and feeds scan, debounce and display-refresh logic with enables instead of derived clocks.

## Interface
- WIDTH, 32: width of free-running count `clkdiv`
- N_CH, 4: number of divider channels (1..16)
- DIV_W, 16: width of each channel's divide value
- DEF_DIV, 1000: divide value loaded into every channel at reset (must be < 2^DIV_W)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  global run enable for channel dividers
- load  in  1  write strobe for divide value
- ch_sel  in  4  channel addressed by `load`
- div_val  in  DIV_W  divide value written on `load`
- clkdiv  out  WIDTH  free-running count
- tick  out  N_CH  per-channel one-cycle enable pulse
- sq  out  N_CH  per-channel square wave, toggles on each tick

## Operation
- Reset (rst=0, asynchronous, any time): clkdiv=0, tick=0, sq=0, every cnt[i]=0, every div[i]=DEF_DIV. Takes effect immediately; no edge needed.
- clkdiv increments by 1 every clock regardless of en. It wraps from 2^WIDTH-1 to 0.
- Per channel i, evaluated on each rising edge, in priority order:
  1. load=1 and ch_sel==i: div[i]<=div_val, cnt[i]<=0, tick[i]<=0, sq[i] held.
  2. en=0: cnt[i] held, tick[i]<=0, sq[i] held.
  3. div[i]==0: channel disabled; cnt[i]<=0, tick[i]<=0, sq[i] held.
  4. cnt[i]==div[i]-1: cnt[i]<=0, tick[i]<=1, sq[i]<=~sq[i].
  5. Otherwise: cnt[i]<=cnt[i]+1, tick[i]<=0.
- cnt[i] is DIV_W bits wide. The comparison uses div[i]-1 in DIV_W bits, and is never reached when div[i]==0.
- Divide value D≥1 gives a tick period of D cycles and an sq period of 2D cycles.
- D=1: tick stays high continuously while en=1, and sq toggles every cycle.
- ch_sel ≥ N_CH with load=1 is ignored. No channel changes and no error is flagged.
- A load into one channel does not disturb the other channels.
- A load while en=0 is still accepted.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- tick latency: after a load of D at edge t with en=1 from then on, tick[i] is high for one cycle following edges t+D, t+2D, ….
- en low for k cycles stretches the current period by exactly k cycles, because cnt is frozen rather than cleared.
- If load and a terminal count coincide on the same channel, load wins: no tick, and sq does not toggle.
- Release of rst is synchronised externally. The first clkdiv increment happens on the first edge with rst=1.

## Test plan
- Reset check: assert rst=0 mid-run with ticks pending. Require all outputs 0 immediately, then after release clkdiv=1 after the first edge and ch0 ticking every DEF_DIV cycles.
- Load D=5 on ch1 with en=1. Require tick[1] pulses 5 cycles apart, first pulse 5 cycles after the load edge, and sq[1] period 10 cycles. The other channels keep their phase.
- Edge values on ch2: D=1 gives tick[2] constantly 1 and sq[2] alternating every cycle. D=0 gives tick[2]=0 forever with sq[2] frozen.
- Drop en for 3 cycles mid-period with D=4. Require the next tick delayed by exactly 3 cycles, and clkdiv still incrementing during the pause.
- Collisions: load on the cycle cnt==D-1 requires no tick and sq held. load with ch_sel=N_CH requires no state change on any channel.
- Wrap: force WIDTH=8 and run 260 cycles. Require clkdiv to go 255→0 with no glitch on tick.
